// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control unit with memory ready/wait handshake, watchdog and trap reporting.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module mc_controller_hs #(
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter int unsigned TMO_W        = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       AluControl,
  output logic             done,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [4:0] {
    StRst, StFetch, StDecode, StLwAdr, StLwMem, StLwWb, StSwAdr, StSwMem, StExecR,
    StExecI, StAluWb, StBranch, StJalrAdr, StJalTgt, StJump, StLinkWb, StLui, StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;

  logic is_r, is_i, is_b, illegal_fields, timed_out, func3_alu_sub;
  logic [2:0] func3_alu;

  assign is_r = (op == 7'b0110011);
  assign is_i = (op == 7'b0010011);
  assign is_b = (op == 7'b1100011);

  assign illegal_fields =
      ((is_r || is_i) && (func3 == 3'b001 || func3 == 3'b101)) ||
      (is_b && (func3 == 3'b010 || func3 == 3'b011)) ||
      (is_r && !(func7 == 7'b0000000 || func7 == 7'b0100000)) ||
      (is_r && func7 == 7'b0100000 && func3 != 3'b000);

  // Counter reaches the limit on this edge while the access is still pending.
  assign timed_out = (WAIT_TIMEOUT != 0) && !mem_ready &&
                     (wait_q == TMO_W'(WAIT_TIMEOUT - 1));

  assign func3_alu_sub = (state_q == StExecR) && (func7 == 7'b0100000);

  always_comb begin
    func3_alu = 3'b000;
    unique case (func3)
      3'b000:  func3_alu = func3_alu_sub ? 3'b001 : 3'b000;
      3'b111:  func3_alu = 3'b010;
      3'b110:  func3_alu = 3'b011;
      3'b100:  func3_alu = 3'b100;
      3'b010:  func3_alu = 3'b101;
      3'b011:  func3_alu = 3'b110;
      default: func3_alu = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch, StLwMem, StSwMem: begin
        if (mem_ready) begin
          state_d = (state_q == StFetch) ? StDecode :
                    (state_q == StLwMem) ? StLwWb : StFetch;
        end else if (timed_out) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      StDecode: begin
        unique case (op)
          7'b0000011: state_d = StLwAdr;
          7'b0100011: state_d = StSwAdr;
          7'b0110011: state_d = StExecR;
          7'b0010011: state_d = StExecI;
          7'b1100011: state_d = StBranch;
          7'b1100111: state_d = StJalrAdr;
          7'b1101111: state_d = StJalTgt;
          7'b0110111: state_d = StLui;
          default:    state_d = StTrap;
        endcase
        if (state_d == StTrap || illegal_fields) begin
          state_d = StTrap;
          cause_d = 2'b01;
        end
      end
      StLwAdr:                   state_d = StLwMem;
      StLwWb, StAluWb, StBranch: state_d = StFetch;
      StSwAdr:                   state_d = StSwMem;
      StExecR, StExecI, StLui:   state_d = StAluWb;
      StJalrAdr, StJalTgt:       state_d = StJump;
      StJump:                    state_d = StLinkWb;
      StLinkWb:                  state_d = StFetch;
      StTrap:                    state_d = StTrap;
      default:                   state_d = StRst;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRst;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    AluSrcA    = 2'b00;
    AluSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    AluControl = 3'b000;
    done       = 1'b0;
    unique case (state_q)
      StFetch: begin
        AluSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      StDecode: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        ImmSrc  = 3'b010;
      end
      StLwAdr, StJalrAdr: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
      end
      StLwMem: AdrSrc = 1'b1;
      StLwWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StSwAdr: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        ImmSrc  = 3'b001;
      end
      StSwMem: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        AluSrcA    = 2'b10;
        AluControl = func3_alu;
      end
      StExecI: begin
        AluSrcA    = 2'b10;
        AluSrcB    = 2'b01;
        AluControl = func3_alu;
      end
      StAluWb, StLinkWb: RegWrite = 1'b1;
      StBranch: begin
        AluSrcA    = 2'b10;
        AluControl = 3'b001;
        unique case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = ~zero;
          3'b100:  PCWrite = lt;
          3'b101:  PCWrite = ~lt;
          3'b110:  PCWrite = ltu;
          3'b111:  PCWrite = ~ltu;
          default: PCWrite = 1'b0;
        endcase
      end
      StJalTgt: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      StJump: begin
        PCWrite = 1'b1;
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
      end
      StLui: begin
        ImmSrc     = 3'b100;
        AluSrcB    = 2'b01;
        AluControl = 3'b111;
      end
      StTrap:  done = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;

`ifdef MC_INSTRET_EN
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  assign retire = (state_q inside {StBranch, StLwWb, StAluWb, StLinkWb}) ||
                  (state_q == StSwMem && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (retire && (instret_q != '1)) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_controller_hs.sv
// Randomized bench: each instruction is expanded into a per-cycle list of expected strobes.
module tb_mc_controller_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, done;
  logic [1:0]  ResultSrc, AluSrcA, AluSrcB, trap_cause;
  logic [2:0]  ImmSrc, AluControl;
  logic [31:0] instret;
  logic [19:0] obs;

  mc_controller_hs #(.WAIT_TIMEOUT(4), .TMO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .lt(lt),
    .ltu(ltu), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ImmSrc(ImmSrc), .AluControl(AluControl),
    .done(done), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, AluSrcA, AluSrcB,
                ImmSrc, AluControl, done, trap_cause};

  typedef struct {
    logic        rdy;
    logic [2:0]  flg;
    logic [19:0] exp;
  } step_t;

  step_t       steps[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned model_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] ov(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [2:0] alu,
                                     input logic dn, input logic [1:0] cs);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, dn, cs};
  endfunction

  task automatic push(input logic rdy, input logic [19:0] exp);
    step_t s;
    s.rdy = rdy;
    s.flg = 3'($urandom_range(0, 7));
    s.exp = exp;
    steps.push_back(s);
  endtask

  task automatic push_rnd(input logic [19:0] exp);
    push(1'($urandom_range(0, 1)), exp);
  endtask

  task automatic push_trap(input logic [1:0] cs);
    for (int k = 0; k < 2; k++) push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, cs));
  endtask

  // Expand one instruction into expected cycles; flg = {zero, lt, ltu} used in the branch cycle.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input int fw, input int mw, input bit stuck, input logic [2:0] flg,
                       output bit trapped);
    bit          legal;
    logic [2:0]  alu;
    logic        take;
    logic [19:0] lw_mem, sw_mem;
    step_t       s;
    steps.delete();
    trapped = 0;
    lw_mem = ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    sw_mem = ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00);
    for (int k = 0; k < fw; k++) push(0, ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 2'b00));
    push(1, ov(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 2'b00));
    push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0, 2'b00));

    case (o)
      7'b0110011: legal = !(f3 == 3'd1 || f3 == 3'd5) && (f7 == 7'h00 || f7 == 7'h20) &&
                          !(f7 == 7'h20 && f3 != 3'd0);
      7'b0010011: legal = !(f3 == 3'd1 || f3 == 3'd5);
      7'b1100011: legal = !(f3 == 3'd2 || f3 == 3'd3);
      7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0110111: legal = 1;
      default:    legal = 0;
    endcase
    case (f3)
      3'd0:    alu = (o == 7'b0110011 && f7 == 7'h20) ? 3'b001 : 3'b000;
      3'd7:    alu = 3'b010;
      3'd6:    alu = 3'b011;
      3'd4:    alu = 3'b100;
      3'd2:    alu = 3'b101;
      3'd3:    alu = 3'b110;
      default: alu = 3'b000;
    endcase
    case (f3)
      3'd0:    take = flg[2];
      3'd1:    take = !flg[2];
      3'd4:    take = flg[1];
      3'd5:    take = !flg[1];
      3'd6:    take = flg[0];
      3'd7:    take = !flg[0];
      default: take = 0;
    endcase

    if (!legal) begin
      push_trap(2'b01);
      trapped = 1;
    end else begin
      case (o)
        7'b0000011: begin
          push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 2'b00));
          for (int k = 0; k < mw; k++) push(0, lw_mem);
          push(1, lw_mem);
          push_rnd(ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00));
        end
        7'b0100011: begin
          push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0, 2'b00));
          if (stuck) begin
            for (int k = 0; k < 4; k++) push(0, sw_mem);
            push_trap(2'b10);
            trapped = 1;
          end else begin
            for (int k = 0; k < mw; k++) push(0, sw_mem);
            push(1, sw_mem);
          end
        end
        7'b0110011, 7'b0010011, 7'b0110111: begin
          if (o == 7'b0110011)
            push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0, 2'b00));
          else if (o == 7'b0010011)
            push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0, 2'b00));
          else
            push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 3'b111, 0, 2'b00));
          push_rnd(ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00));
        end
        7'b1100011: begin
          s.rdy = 1'($urandom_range(0, 1));
          s.flg = flg;
          s.exp = ov(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0, 2'b00);
          steps.push_back(s);
        end
        default: begin // jalr / jal
          if (o == 7'b1100111)
            push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 2'b00));
          else
            push_rnd(ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 0, 2'b00));
          push_rnd(ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 2'b00));
          push_rnd(ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00));
        end
      endcase
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef MC_INSTRET_EN
    return model_ret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic apply(input string tag);
    for (int i = 0; i < steps.size(); i++) begin
      @(negedge clk);
      mem_ready = steps[i].rdy;
      {zero, lt, ltu} = steps[i].flg;
      #1;
      if (i == 0) check_eq({tag, ".instret"}, instret, exp_instret());
      check_eq(tag, {12'd0, obs}, {12'd0, steps[i].exp});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_ret = 0;
    check_eq("reset.out", {12'd0, obs}, 32'd0);
    check_eq("reset.instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_state.out", {12'd0, obs}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input int fw, input int mw, input bit stuck,
                     input logic [2:0] flg);
    bit trapped;
    build(o, f3, f7, fw, mw, stuck, flg, trapped);
    op = o;
    func3 = f3;
    func7 = f7;
    apply(tag);
    if (trapped) do_reset();
    else model_ret++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [6:0] ops[8];
    logic [6:0] o;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1100111,
            7'b1101111, 7'b0110111};
    repeat (3) @(negedge clk);
    #1;
    check_eq("por.out", {12'd0, obs}, 32'd0);
    check_eq("por.instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("por_rst_state.out", {12'd0, obs}, 32'd0);

    run("add",       7'b0110011, 3'b000, 7'h00, 0, 0, 0, 3'b000);
    run("sub",       7'b0110011, 3'b000, 7'h20, 0, 0, 0, 3'b000);
    run("addi_f7",   7'b0010011, 3'b000, 7'h20, 1, 0, 0, 3'b000);
    run("bltu",      7'b1100011, 3'b110, 7'h00, 0, 0, 0, 3'b001);
    run("bge",       7'b1100011, 3'b101, 7'h00, 0, 0, 0, 3'b010);
    run("lw_wait3",  7'b0000011, 3'b010, 7'h00, 0, 3, 0, 3'b000);
    run("sw_stuck",  7'b0100011, 3'b010, 7'h00, 0, 0, 1, 3'b000);
    run("jal",       7'b1101111, 3'b000, 7'h00, 2, 0, 0, 3'b000);
    run("illegal",   7'b0000000, 3'b000, 7'h00, 0, 0, 0, 3'b000);
    run("lui",       7'b0110111, 3'b000, 7'h00, 0, 0, 0, 3'b000);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 7)];
      run("rand", o, 3'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) :
          (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20), $urandom_range(0, 3),
          $urandom_range(0, 3), ($urandom_range(0, 15) == 0), 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
